// File: rtl/ram_arb.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// instruction-fetch port and the data port, hiding the RAM's read latency.
module ram_arb #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_LEN-3:0]   i_addr,
  input  logic                  i_rd_req,
  output logic                  i_rd_ready,
  output logic [XLEN-1:0]       i_rd_data,
  input  logic [ADDR_LEN-3:0]   d_addr,
  input  logic                  d_rd_req,
  input  logic                  d_wr_req,
  input  logic [XLEN/8-1:0]     d_be,
  input  logic [XLEN-1:0]       d_wr_data,
  output logic                  d_rd_ready,
  output logic                  d_wr_ready,
  output logic [XLEN-1:0]       d_rd_data,
  output logic [ADDR_LEN-3:0]   ram_addr,
  output logic                  ram_en,
  output logic [XLEN/8-1:0]     ram_we,
  output logic [XLEN-1:0]       ram_wr_data,
  input  logic [XLEN-1:0]       ram_rd_data
);

  typedef enum logic [1:0] {IDLE, ACC_I, ACC_D} state_t;

  state_t state;
  logic   last_gnt_d;
  logic   i_rdy_q;
  logic   d_rd_rdy_q;
  logic   d_wr_rdy_q;
  logic   i_want;
  logic   d_want;
  logic   issue_i;
  logic   issue_d;

  assign i_want = i_rd_req;
  assign d_want = d_rd_req | d_wr_req;

  // In an ACC state only the other port may be issued: the completing port's
  // request is still high but belongs to the access being retired.
  always_comb begin
    issue_i = 1'b0;
    issue_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_want && d_want) begin
          issue_i = last_gnt_d;
          issue_d = !last_gnt_d;
        end else begin
          issue_i = i_want;
          issue_d = d_want;
        end
      end
      ACC_I:   issue_d = d_want;
      ACC_D:   issue_i = i_want;
      default: ;
    endcase
    if (rst) begin
      issue_i = 1'b0;
      issue_d = 1'b0;
    end
  end

  assign ram_en      = issue_i | issue_d;
  assign ram_addr    = issue_d ? d_addr : i_addr;
  assign ram_we      = (issue_d && d_wr_req) ? d_be : '0;
  assign ram_wr_data = d_wr_data;

  assign i_rd_data = ram_rd_data;
  assign d_rd_data = ram_rd_data;

  // Readys are gated by rst so an access caught by reset never completes.
  assign i_rd_ready = i_rdy_q & ~rst;
  assign d_rd_ready = d_rd_rdy_q & ~rst;
  assign d_wr_ready = d_wr_rdy_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_gnt_d <= 1'b1;
      i_rdy_q    <= 1'b0;
      d_rd_rdy_q <= 1'b0;
      d_wr_rdy_q <= 1'b0;
    end else begin
      if (issue_i)
        state <= ACC_I;
      else if (issue_d)
        state <= ACC_D;
      else
        state <= IDLE;

      if (state == ACC_I)
        last_gnt_d <= 1'b0;
      else if (state == ACC_D)
        last_gnt_d <= 1'b1;

      i_rdy_q    <= issue_i;
      d_rd_rdy_q <= issue_d & ~d_wr_req;
      d_wr_rdy_q <= issue_d & d_wr_req;
    end
  end

endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb with a behavioural synchronous RAM model and
// hand-computed expected values.
module tb_ram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] i_addr;
  logic        i_rd_req;
  logic        i_rd_ready;
  logic [31:0] i_rd_data;
  logic [11:0] d_addr;
  logic        d_rd_req;
  logic        d_wr_req;
  logic [3:0]  d_be;
  logic [31:0] d_wr_data;
  logic        d_rd_ready;
  logic        d_wr_ready;
  logic [31:0] d_rd_data;
  logic [11:0] ram_addr;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_wr_data;
  logic [31:0] ram_rd_data;

  logic [31:0] mem [0:4095];
  int vectors = 0;
  int miscompares = 0;

  ram_arb #(.XLEN(32), .ADDR_LEN(14)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_rd_req(i_rd_req), .i_rd_ready(i_rd_ready), .i_rd_data(i_rd_data),
    .d_addr(d_addr), .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_be(d_be),
    .d_wr_data(d_wr_data), .d_rd_ready(d_rd_ready), .d_wr_ready(d_wr_ready),
    .d_rd_data(d_rd_data), .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  // RAM returns the pre-write contents of the addressed word one cycle later
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
      ram_rd_data <= mem[ram_addr];
    end
  end

  task automatic applyStimulus(input logic r, input logic ir, input logic [11:0] ia,
                               input logic dr, input logic dw, input logic [11:0] da,
                               input logic [3:0] be, input logic [31:0] wd);
    @(negedge clk);
    rst = r; i_rd_req = ir; i_addr = ia;
    d_rd_req = dr; d_wr_req = dw; d_addr = da; d_be = be; d_wr_data = wd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " ram_en"}, {31'd0, ram_en}, 32'd0);
    checkOutput({tag, " ram_we"}, {28'd0, ram_we}, 32'd0);
    checkOutput({tag, " readys"}, {29'd0, i_rd_ready, d_rd_ready, d_wr_ready}, 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 4096; k++) mem[k] = 32'hA000_0000 | k;
    mem[12'h010] = 32'hDEAD_BEEF;
    mem[12'h004] = 32'h1122_3344;
    rst = 1'b1; i_rd_req = 1'b0; i_addr = '0; d_rd_req = 1'b0; d_wr_req = 1'b0;
    d_addr = '0; d_be = '0; d_wr_data = '0;
    $display("[TB] starting ram_arb directed run");

    // Reset held with both ports requesting: nothing may reach the RAM
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 12'h020, 0, 1, 12'h004, 4'hF, 32'hFFFF_FFFF);
      checkIdle("reset");
    end

    // First tie after reset goes to I; the data write follows
    applyStimulus(0, 1, 12'h020, 0, 1, 12'h030, 4'hF, 32'hCAFE_F00D);
    checkOutput("tie ram_en", {31'd0, ram_en}, 32'd1);
    checkOutput("tie ram_addr", {20'd0, ram_addr}, 32'h020);
    checkOutput("tie ram_we", {28'd0, ram_we}, 32'd0);
    applyStimulus(0, 1, 12'h020, 0, 1, 12'h030, 4'hF, 32'hCAFE_F00D);
    checkOutput("tie i_rd_ready", {31'd0, i_rd_ready}, 32'd1);
    checkOutput("tie i_rd_data", i_rd_data, 32'hA000_0020);
    checkOutput("tie d ram_addr", {20'd0, ram_addr}, 32'h030);
    checkOutput("tie d ram_we", {28'd0, ram_we}, 32'hF);
    checkOutput("tie d ram_wr_data", ram_wr_data, 32'hCAFE_F00D);
    applyStimulus(0, 0, 12'h000, 0, 1, 12'h030, 4'hF, 32'hCAFE_F00D);
    checkOutput("tie d_wr_ready", {31'd0, d_wr_ready}, 32'd1);
    checkOutput("tie d_rd_ready", {31'd0, d_rd_ready}, 32'd0);
    checkOutput("tie no reissue", {31'd0, ram_en}, 32'd0);
    applyStimulus(0, 0, 12'h000, 0, 0, 12'h000, 4'h0, 32'h0);
    checkIdle("idle after tie");

    // Single data read
    applyStimulus(0, 0, 12'h000, 1, 0, 12'h010, 4'h0, 32'h0);
    checkOutput("rd ram_en", {31'd0, ram_en}, 32'd1);
    checkOutput("rd ram_addr", {20'd0, ram_addr}, 32'h010);
    checkOutput("rd ram_we", {28'd0, ram_we}, 32'd0);
    applyStimulus(0, 0, 12'h000, 1, 0, 12'h010, 4'h0, 32'h0);
    checkOutput("rd d_rd_ready", {31'd0, d_rd_ready}, 32'd1);
    checkOutput("rd d_rd_data", d_rd_data, 32'hDEAD_BEEF);
    checkOutput("rd d_wr_ready", {31'd0, d_wr_ready}, 32'd0);
    checkOutput("rd no reissue", {31'd0, ram_en}, 32'd0);
    applyStimulus(0, 0, 12'h000, 1, 0, 12'h030, 4'h0, 32'h0);
    applyStimulus(0, 0, 12'h000, 1, 0, 12'h030, 4'h0, 32'h0);
    checkOutput("readback 030", d_rd_data, 32'hCAFE_F00D);
    checkOutput("readback 030 ready", {31'd0, d_rd_ready}, 32'd1);

    // Byte write into word 0x004 then read it back
    applyStimulus(0, 0, 12'h000, 0, 1, 12'h004, 4'b0010, 32'h0000_AB00);
    checkOutput("bw ram_we", {28'd0, ram_we}, 32'h2);
    checkOutput("bw ram_addr", {20'd0, ram_addr}, 32'h004);
    checkOutput("bw ram_wr_data", ram_wr_data, 32'h0000_AB00);
    applyStimulus(0, 0, 12'h000, 0, 1, 12'h004, 4'b0010, 32'h0000_AB00);
    checkOutput("bw d_wr_ready", {31'd0, d_wr_ready}, 32'd1);
    checkOutput("bw we in ready cycle", {28'd0, ram_we}, 32'd0);
    applyStimulus(0, 0, 12'h000, 0, 0, 12'h000, 4'h0, 32'h0);
    checkIdle("idle after bw");
    applyStimulus(0, 0, 12'h000, 1, 0, 12'h004, 4'h0, 32'h0);
    applyStimulus(0, 0, 12'h000, 1, 0, 12'h004, 4'h0, 32'h0);
    checkOutput("bw readback", d_rd_data, 32'h1122_AB44);

    // Read and write together is a write
    applyStimulus(0, 0, 12'h000, 1, 1, 12'h005, 4'b1000, 32'h5500_0000);
    checkOutput("rw ram_we", {28'd0, ram_we}, 32'h8);
    applyStimulus(0, 0, 12'h000, 1, 1, 12'h005, 4'b1000, 32'h5500_0000);
    checkOutput("rw d_wr_ready", {31'd0, d_wr_ready}, 32'd1);
    checkOutput("rw d_rd_ready", {31'd0, d_rd_ready}, 32'd0);
    applyStimulus(0, 0, 12'h000, 1, 0, 12'h005, 4'h0, 32'h0);
    checkOutput("rw no extra ready", {30'd0, d_rd_ready, d_wr_ready}, 32'd0);
    applyStimulus(0, 0, 12'h000, 1, 0, 12'h005, 4'h0, 32'h0);
    checkOutput("rw readback", d_rd_data, 32'h5500_0005);

    // Contention: last grant was D, so I wins and the ports alternate
    applyStimulus(0, 1, 12'h040, 1, 0, 12'h041, 4'h0, 32'h0);
    checkOutput("ct0 ram_addr", {20'd0, ram_addr}, 32'h040);
    for (int k = 1; k <= 6; k++) begin
      if (k % 2 == 0)
        applyStimulus(0, 1, 12'h040 + 12'(k), 1, 0, d_addr, 4'h0, 32'h0);
      else
        applyStimulus(0, 1, i_addr, 1, 0, (k == 1) ? 12'h041 : 12'h040 + 12'(k), 4'h0, 32'h0);
      checkOutput($sformatf("ct%0d ram_en", k), {31'd0, ram_en}, 32'd1);
      checkOutput($sformatf("ct%0d ram_addr", k), {20'd0, ram_addr}, 32'h040 + k);
      checkOutput($sformatf("ct%0d readys", k), {30'd0, i_rd_ready, d_rd_ready},
                  (k % 2 == 1) ? 32'd2 : 32'd1);
      checkOutput($sformatf("ct%0d data", k), (k % 2 == 1) ? i_rd_data : d_rd_data,
                  32'hA000_0040 + (k - 1));
    end
    applyStimulus(0, 1, 12'h046, 0, 0, 12'h000, 4'h0, 32'h0);
    checkOutput("ct7 i_rd_ready", {31'd0, i_rd_ready}, 32'd1);
    checkOutput("ct7 i_rd_data", i_rd_data, 32'hA000_0046);
    checkOutput("ct7 ram_en", {31'd0, ram_en}, 32'd0);
    applyStimulus(0, 0, 12'h000, 0, 0, 12'h000, 4'h0, 32'h0);
    checkIdle("idle after ct");

    // Reset in the cycle after an I grant drops that access
    applyStimulus(0, 1, 12'h050, 0, 0, 12'h000, 4'h0, 32'h0);
    checkOutput("mr grant", {31'd0, ram_en}, 32'd1);
    applyStimulus(1, 1, 12'h050, 0, 0, 12'h000, 4'h0, 32'h0);
    checkIdle("mr in reset");
    applyStimulus(0, 1, 12'h050, 0, 0, 12'h000, 4'h0, 32'h0);
    checkOutput("mr reissue ram_en", {31'd0, ram_en}, 32'd1);
    checkOutput("mr reissue addr", {20'd0, ram_addr}, 32'h050);
    checkOutput("mr no stale ready", {31'd0, i_rd_ready}, 32'd0);
    applyStimulus(0, 1, 12'h050, 0, 0, 12'h000, 4'h0, 32'h0);
    checkOutput("mr i_rd_ready", {31'd0, i_rd_ready}, 32'd1);
    checkOutput("mr i_rd_data", i_rd_data, 32'hA000_0050);
    applyStimulus(0, 0, 12'h000, 0, 0, 12'h000, 4'h0, 32'h0);
    checkIdle("final idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arb.md
# ram_arb

Two-port arbiter that shares the single-port synchronous data/instruction RAM between the instruction-fetch port (read-only) and the data port fed by the core's data-side address decoder. It sequences RAM enables and write strobes and returns per-port ready pulses with the RAM's one-cycle read latency hidden behind a req/ready handshake. When both ports request, grants alternate round-robin, giving one access per cycle.

## Interface
- XLEN, 32, data width; byte enables are XLEN/8 bits wide
- ADDR_LEN, 14, byte-address width; word addresses are ADDR_LEN-2 bits wide

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- i_addr  in  ADDR_LEN-2  fetch word address
- i_rd_req  in  1  fetch read request, held until i_rd_ready
- i_rd_ready  out  1  one-cycle pulse; i_rd_data valid in the same cycle
- i_rd_data  out  XLEN  fetch read data
- d_addr  in  ADDR_LEN-2  data word address
- d_rd_req  in  1  data read request, held until d_rd_ready
- d_wr_req  in  1  data write request, held until d_wr_ready
- d_be  in  XLEN/8  write byte enables
- d_wr_data  in  XLEN  write data
- d_rd_ready  out  1  one-cycle pulse; d_rd_data valid in the same cycle
- d_wr_ready  out  1  one-cycle pulse; the write has been committed to RAM
- d_rd_data  out  XLEN  data read data
- ram_addr  out  ADDR_LEN-2  RAM word address
- ram_en  out  1  RAM access enable
- ram_we  out  XLEN/8  RAM byte write enables
- ram_wr_data  out  XLEN  RAM write data
- ram_rd_data  in  XLEN  RAM read data, valid one cycle after ram_en

## Operation
- Requester contract: req, addr, be and wr_data are held stable from assertion until the cycle the matching ready is high. The requester deasserts or presents a new request in the following cycle.
- d_rd_req and d_wr_req asserted together is treated as a write. d_wr_ready pulses and d_rd_ready stays low.
- FSM states: IDLE, ACC_I, ACC_D. The state names which port's RAM access is completing this cycle.
- Issue logic is combinational from state and requests. The issued port drives ram_en=1, ram_addr, ram_wr_data=d_wr_data, and ram_we=d_be for a write (0 otherwise).
- IDLE:
  - Only one port requesting: issue it and go to ACC_<port>.
  - Both requesting: issue the port not served last (last_gnt register) and go to its ACC state.
  - No request: stay in IDLE with ram_en=0.
- ACC_X:
  - Assert X's ready for one cycle.
  - Drive X's rd_data = ram_rd_data.
  - Set last_gnt = X.
  - The other port Y is then checked. If Y is requesting, issue Y in the same cycle and go to ACC_Y. Otherwise go to IDLE.
  - X's still-high request is never re-issued in ACC_X, because it is the request being retired.
- i_rd_data and d_rd_data pass ram_rd_data straight through. Their value is only meaningful while the matching ready is high.
- Ready outputs are registered-state decodes and never depend combinationally on req.

## Timing
- Reset values: state=IDLE, last_gnt=D (so I wins the first tie), all ready outputs 0. ram_en=0 and ram_we=0 in every cycle rst is high, regardless of requests.
- Latency: a request issued in cycle T gets its ready in cycle T+1. From IDLE with no contention, req-to-ready is 1 cycle.
- Throughput with both ports continuously requesting: strict alternation I,D,I,D. Each port sees ready every 2 cycles; the RAM is enabled every cycle.
- Single-port streaming: back-to-back accesses from the same port take 2 cycles each (ACC_X then IDLE then issue). This is intentional, because the held request cannot be told apart from a new one in the ACC cycle.
- Reset mid-access: an in-flight access is dropped. No ready is produced for it, and the requester re-issues after rst falls. A write already strobed in the grant cycle may have been committed.
- Write commit: ram_we is asserted in the grant cycle only, never in the ready cycle.

## Test plan
- Reset: hold rst 3 cycles with i_rd_req=d_wr_req=1 -> ram_en=0, ram_we=0 and all readys 0 throughout. After release, state=IDLE and the first grant goes to I.
- Single read: d_rd_req=1, d_addr=0x010, RAM word 0x010=0xDEADBEEF -> ram_en=1 and ram_addr=0x010 in cycle T; d_rd_ready=1 and d_rd_data=0xDEADBEEF in T+1.
- Byte write then read: d_wr_req, d_be=4'b0010, d_wr_data=0x0000AB00 at word 0x004 holding 0x11223344 -> ram_we=4'b0010 in T, d_wr_ready in T+1. A later read returns 0x1122AB44.
- Contention: i_rd_req and d_rd_req held high from reset release, new addresses after each ready -> readys alternate I,D,I,D, ram_en=1 every cycle, and no port gets two grants in a row.
- Simultaneous d_rd_req and d_wr_req -> the access is a write: ram_we=d_be and d_wr_ready pulses once; d_rd_ready stays 0.
- Reset mid-access: assert rst in the cycle after an I grant -> no i_rd_ready. After release, I re-requests and completes normally.
